// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - variable-length (16/32-bit) instruction fetch into the IF/ID register
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] next_pc,
    output logic        pc_enable,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
);

    typedef enum logic {ST_FIRST, ST_SECOND} state_e;

    state_e      state_q, state_d;
    logic [15:0] hold_word_q, hold_word_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    assign imem_addr  = pc_in;
    assign next_pc    = pc_in + 32'd1;
    assign pc_enable  = ~stall | flush;
    assign ifid_instr = instr_q;
    assign ifid_pc    = pc_q;
    assign ifid_valid = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit 15 is only a length marker on an opcode word; immediates never redirect the FSM.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FIRST;
        end else if (!stall) begin
            case (state_q)
                ST_FIRST:  state_d = imem_data[15] ? ST_SECOND : ST_FIRST;
                ST_SECOND: state_d = ST_FIRST;
                default:   state_d = ST_FIRST;
            endcase
        end
    end

    always_comb begin
        hold_word_d = hold_word_q;
        hold_pc_d   = hold_pc_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        if (flush) begin
            instr_d = 32'h0;
            pc_d    = 32'h0;
            valid_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_FIRST: begin
                    if (imem_data[15]) begin
                        hold_word_d = imem_data;
                        hold_pc_d   = pc_in;
                        valid_d     = 1'b0;
                    end else begin
                        instr_d = {16'h0000, imem_data};
                        pc_d    = pc_in;
                        valid_d = 1'b1;
                    end
                end
                ST_SECOND: begin
                    instr_d = {hold_word_q, imem_data};
                    pc_d    = hold_pc_q;
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_word_q <= 16'h0;
            hold_pc_q   <= 32'h0;
            instr_q     <= 32'h0;
            pc_q        <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            hold_word_q <= hold_word_d;
            hold_pc_q   <= hold_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

endmodule
